// File: rtl/drac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : drac_pkg
//  Description : Shared fetch-side types for the icache line responder.
//                Line, index, vpn and address types plus the responder's
//                state enumeration.
//  Revision    : 1.0 - initial release
// ============================================================================
package drac_pkg;

  // Widths of the fetch-side address and the cache line
  localparam int PHY_VIRT_MAX_ADDR_SIZE = 40;
  localparam int ICACHE_LINE_W          = 128;
  localparam int ICACHE_IDX_W           = 12;
  localparam int ICACHE_OFFSET_W        = 4;   // byte offset within a 16-byte line

  typedef logic [ICACHE_LINE_W-1:0]                       icache_line_t;
  typedef logic [ICACHE_IDX_W-1:0]                        icache_idx_t;
  typedef logic [PHY_VIRT_MAX_ADDR_SIZE-ICACHE_IDX_W-1:0] icache_vpn_t;
  typedef logic [PHY_VIRT_MAX_ADDR_SIZE-1:0]              addr_t;

  // Responder control states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2,
    RESP      = 2'd3
  } icache_resp_state_t;

endpackage : drac_pkg
`default_nettype wire

// File: rtl/icache_line_array.sv
`default_nettype none
// ============================================================================
//  Module      : icache_line_array
//  Description : Direct-mapped, flop-based tag/data store with a valid-bit
//                vector. One combinational read port, one write port and a
//                flash clear of all valid bits. Tag and data are not reset.
//  Ports       : clk_i, rstn_i      - clock, async active-low reset
//                rd_set_i           - read set index
//                rd_valid_o/tag_o/data_o - combinational read of that set
//                wr_en_i, wr_set_i, wr_tag_i, wr_data_i, wr_valid_i - write
//                flush_i            - clear every valid bit (wins over write)
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_line_array #(
  parameter int NUM_SETS = 64,
  parameter int SET_W    = $clog2(NUM_SETS),
  parameter int TAG_W    = 30,
  parameter int LINE_W   = 128
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [SET_W-1:0]  rd_set_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [SET_W-1:0]  wr_set_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [LINE_W-1:0] wr_data_i,
  input  logic              wr_valid_i,
  input  logic              flush_i
);

  logic [NUM_SETS-1:0] r_valid;
  logic [TAG_W-1:0]    r_tag  [NUM_SETS];
  logic [LINE_W-1:0]   r_data [NUM_SETS];

  // A flash clear in the same cycle as a fill leaves the filled line invalid.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_valid <= '0;
    end else if (flush_i) begin
      r_valid <= '0;
    end else if (wr_en_i) begin
      r_valid[wr_set_i] <= wr_valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      r_tag[wr_set_i]  <= wr_tag_i;
      r_data[wr_set_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = r_valid[rd_set_i];
  assign rd_tag_o   = r_tag[rd_set_i];
  assign rd_data_o  = r_data[rd_set_i];

endmodule : icache_line_array
`default_nettype wire

// File: rtl/icache_line_responder.sv
`default_nettype none
// ============================================================================
//  Module      : icache_line_responder
//  Description : Responder end of the fetch-side icache protocol. Direct-
//                mapped flop line store; hits answered one cycle after
//                acceptance, misses refilled through a single-beat memory
//                port. Identity translation (vaddr = paddr).
//  Ports       : clk_i, rstn_i                  - clock, async active-low reset
//                icache_req_*_i, icache_req_ready_o - fetch request side
//                icache_invalidate_i            - flash invalidate
//                icache_resp_*_o                - line response (1-cycle pulse)
//                mem_req_*, mem_resp_*          - refill memory port
//                hit_o, miss_o                  - per-request PMU pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_line_responder
  import drac_pkg::*;
#(
  parameter int NUM_SETS = 64,
  parameter int ADDR_W   = PHY_VIRT_MAX_ADDR_SIZE,
  parameter int LINE_W   = ICACHE_LINE_W
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              icache_req_valid_i,
  input  logic [11:0]       icache_req_bits_idx_i,
  input  logic [ADDR_W-13:0] icache_req_bits_vpn_i,
  input  logic              icache_req_kill_i,
  input  logic              icache_invalidate_i,
  output logic              icache_req_ready_o,
  output logic              icache_resp_valid_o,
  output logic [LINE_W-1:0] icache_resp_datablock_o,
  output logic [ADDR_W-1:0] icache_resp_vaddr_o,
  output logic              mem_req_valid_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  input  logic              mem_req_ready_i,
  input  logic              mem_resp_valid_i,
  input  logic [LINE_W-1:0] mem_resp_data_i,
  output logic              hit_o,
  output logic              miss_o
);

  localparam int c_off_w = ICACHE_OFFSET_W;
  localparam int c_set_w = $clog2(NUM_SETS);
  localparam int c_tag_w = ADDR_W - c_off_w - c_set_w;

  icache_resp_state_t r_state;
  logic               r_ready;
  logic               r_resp_valid;
  logic [LINE_W-1:0]  r_resp_data;
  logic [ADDR_W-1:0]  r_resp_vaddr;
  logic               r_mem_req_valid;
  logic [ADDR_W-1:0]  r_mem_req_addr;
  logic [ADDR_W-1:0]  r_miss_vaddr;
  logic               r_killed;
  logic               r_inval;
  logic               r_hit;
  logic               r_miss;

  logic [ADDR_W-1:0]  w_req_addr;
  logic [c_set_w-1:0] w_req_set;
  logic [c_tag_w-1:0] w_req_tag;
  logic               w_rd_valid;
  logic [c_tag_w-1:0] w_rd_tag;
  logic [LINE_W-1:0]  w_rd_data;
  logic               w_accept;
  logic               w_hit;
  logic               w_fill;

  assign w_req_addr = {icache_req_bits_vpn_i, icache_req_bits_idx_i};
  assign w_req_set  = w_req_addr[c_off_w +: c_set_w];
  assign w_req_tag  = w_req_addr[ADDR_W-1 -: c_tag_w];

  // ready is a registered copy of "in IDLE", so it reads 0 while in reset.
  assign w_accept = icache_req_valid_i & r_ready & ~icache_req_kill_i & ~icache_invalidate_i;
  assign w_hit    = w_rd_valid & (w_rd_tag == w_req_tag);
  assign w_fill   = (r_state == MISS_WAIT) & mem_resp_valid_i;

  icache_line_array #(
    .NUM_SETS (NUM_SETS),
    .SET_W    (c_set_w),
    .TAG_W    (c_tag_w),
    .LINE_W   (LINE_W)
  ) u_line_array (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .rd_set_i   (w_req_set),
    .rd_valid_o (w_rd_valid),
    .rd_tag_o   (w_rd_tag),
    .rd_data_o  (w_rd_data),
    .wr_en_i    (w_fill),
    .wr_set_i   (r_miss_vaddr[c_off_w +: c_set_w]),
    .wr_tag_i   (r_miss_vaddr[ADDR_W-1 -: c_tag_w]),
    .wr_data_i  (mem_resp_data_i),
    .wr_valid_i (~r_inval),
    .flush_i    (icache_invalidate_i)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state         <= IDLE;
      r_ready         <= 1'b0;
      r_resp_valid    <= 1'b0;
      r_resp_data     <= '0;
      r_resp_vaddr    <= '0;
      r_mem_req_valid <= 1'b0;
      r_mem_req_addr  <= '0;
      r_miss_vaddr    <= '0;
      r_killed        <= 1'b0;
      r_inval         <= 1'b0;
      r_hit           <= 1'b0;
      r_miss          <= 1'b0;
    end else begin
      // Response and PMU outputs are single-cycle pulses.
      r_resp_valid <= 1'b0;
      r_hit        <= 1'b0;
      r_miss       <= 1'b0;

      unique case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            if (w_hit) begin
              r_resp_valid <= 1'b1;
              r_resp_data  <= w_rd_data;
              r_resp_vaddr <= w_req_addr;
              r_hit        <= 1'b1;
            end else begin
              r_miss          <= 1'b1;
              r_ready         <= 1'b0;
              r_state         <= MISS_REQ;
              r_mem_req_valid <= 1'b1;
              r_mem_req_addr  <= {w_req_addr[ADDR_W-1:c_off_w], {c_off_w{1'b0}}};
              r_miss_vaddr    <= w_req_addr;
              r_killed        <= 1'b0;
              r_inval         <= 1'b0;
            end
          end
        end

        MISS_REQ: begin
          if (icache_req_kill_i)   r_killed <= 1'b1;
          if (icache_invalidate_i) r_inval  <= 1'b1;
          if (mem_req_ready_i) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= MISS_WAIT;
          end
        end

        MISS_WAIT: begin
          if (icache_req_kill_i)   r_killed <= 1'b1;
          if (icache_invalidate_i) r_inval  <= 1'b1;
          if (mem_resp_valid_i) begin
            // A kill arriving together with the refill data still suppresses
            // the response; the line fill itself always happens.
            r_resp_valid <= ~(r_killed | icache_req_kill_i);
            r_resp_data  <= mem_resp_data_i;
            r_resp_vaddr <= r_miss_vaddr;
            r_state      <= RESP;
          end
        end

        RESP: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign icache_req_ready_o      = r_ready;
  assign icache_resp_valid_o     = r_resp_valid;
  assign icache_resp_datablock_o = r_resp_data;
  assign icache_resp_vaddr_o     = r_resp_vaddr;
  assign mem_req_valid_o         = r_mem_req_valid;
  assign mem_req_addr_o          = r_mem_req_addr;
  assign hit_o                   = r_hit;
  assign miss_o                  = r_miss;

endmodule : icache_line_responder
`default_nettype wire

// File: tb/tb_icache_line_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_line_responder
//  Description : Self-checking bench for icache_line_responder. Directed
//                scenarios followed by randomized traffic, checked against a
//                set-indexed line model kept in the bench.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_icache_line_responder;
  import drac_pkg::*;

  localparam int NUM_SETS = 64;
  localparam int ADDR_W   = 40;
  localparam int LINE_W   = 128;

  logic              clk_i = 1'b0;
  logic              rstn_i = 1'b0;
  logic              icache_req_valid_i = 1'b0;
  logic [11:0]       icache_req_bits_idx_i = '0;
  logic [ADDR_W-13:0] icache_req_bits_vpn_i = '0;
  logic              icache_req_kill_i = 1'b0;
  logic              icache_invalidate_i = 1'b0;
  logic              icache_req_ready_o;
  logic              icache_resp_valid_o;
  logic [LINE_W-1:0] icache_resp_datablock_o;
  logic [ADDR_W-1:0] icache_resp_vaddr_o;
  logic              mem_req_valid_o;
  logic [ADDR_W-1:0] mem_req_addr_o;
  logic              mem_req_ready_i = 1'b0;
  logic              mem_resp_valid_i = 1'b0;
  logic [LINE_W-1:0] mem_resp_data_i = '0;
  logic              hit_o;
  logic              miss_o;

  always #5 clk_i = ~clk_i;

  icache_line_responder #(
    .NUM_SETS (NUM_SETS),
    .ADDR_W   (ADDR_W),
    .LINE_W   (LINE_W)
  ) dut (
    .clk_i                   (clk_i),
    .rstn_i                  (rstn_i),
    .icache_req_valid_i      (icache_req_valid_i),
    .icache_req_bits_idx_i   (icache_req_bits_idx_i),
    .icache_req_bits_vpn_i   (icache_req_bits_vpn_i),
    .icache_req_kill_i       (icache_req_kill_i),
    .icache_invalidate_i     (icache_invalidate_i),
    .icache_req_ready_o      (icache_req_ready_o),
    .icache_resp_valid_o     (icache_resp_valid_o),
    .icache_resp_datablock_o (icache_resp_datablock_o),
    .icache_resp_vaddr_o     (icache_resp_vaddr_o),
    .mem_req_valid_o         (mem_req_valid_o),
    .mem_req_addr_o          (mem_req_addr_o),
    .mem_req_ready_i         (mem_req_ready_i),
    .mem_resp_valid_i        (mem_resp_valid_i),
    .mem_resp_data_i         (mem_resp_data_i),
    .hit_o                   (hit_o),
    .miss_o                  (miss_o)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model: per set, which line (addr >> 4) it holds and its data.
  bit                m_valid [NUM_SETS];
  logic [ADDR_W-5:0] m_line  [NUM_SETS];
  logic [LINE_W-1:0] m_data  [NUM_SETS];

  // Per-miss kill / invalidate bookkeeping
  bit g_killed;
  bit g_invd;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_SETS; i++) m_valid[i] = 1'b0;
  endtask

  function automatic int set_of(input addr_t a);
    return int'((a >> 4) % NUM_SETS);
  endfunction

  task automatic drive_req(input addr_t a);
    icache_req_valid_i    = 1'b1;
    icache_req_bits_idx_i = a[11:0];
    icache_req_bits_vpn_i = a[ADDR_W-1:12];
  endtask

  // Drive kill / invalidate for miss-phase cycle c when it matches.
  task automatic apply_ctl(input int c, input int kill_cyc, input int inval_cyc);
    icache_req_kill_i   = (c == kill_cyc);
    icache_invalidate_i = (c == inval_cyc);
    if (c == kill_cyc) g_killed = 1'b1;
    if (c == inval_cyc) begin
      g_invd = 1'b1;
      model_clear();
    end
  endtask

  task automatic clear_ctl();
    icache_req_kill_i   = 1'b0;
    icache_invalidate_i = 1'b0;
  endtask

  // One full request. Miss-phase cycles are numbered from 0 (first MISS_REQ
  // cycle); kill_cyc / inval_cyc pick a cycle or -1 for none.
  task automatic access(input addr_t a, input int rdy_dly, input int rsp_dly,
                        input int kill_cyc, input int inval_cyc,
                        input logic [LINE_W-1:0] fill, output bit was_hit);
    int    s;
    int    c;
    bit    exp_hit;
    addr_t line_a;
    s       = set_of(a);
    exp_hit = m_valid[s] && (m_line[s] == a[ADDR_W-1:4]);
    line_a  = {a[ADDR_W-1:4], 4'h0};
    chk("ready_before_req", icache_req_ready_o, 1);
    drive_req(a);
    step();
    icache_req_valid_i = 1'b0;
    was_hit = hit_o;
    chk("hit_o", hit_o, exp_hit);
    chk("miss_o", miss_o, !exp_hit);
    if (exp_hit) begin
      chk("hit_resp_valid", icache_resp_valid_o, 1);
      chk("hit_resp_data", icache_resp_datablock_o, m_data[s]);
      chk("hit_resp_vaddr", icache_resp_vaddr_o, a);
      chk("hit_no_mem_req", mem_req_valid_o, 0);
      return;
    end
    chk("miss_no_resp", icache_resp_valid_o, 0);
    chk("miss_mem_req_valid", mem_req_valid_o, 1);
    chk("miss_mem_req_addr", mem_req_addr_o, line_a);
    chk("miss_ready_low", icache_req_ready_o, 0);
    g_killed = 1'b0;
    g_invd   = 1'b0;
    c        = 0;
    for (int i = 0; i < rdy_dly; i++) begin
      apply_ctl(c, kill_cyc, inval_cyc);
      step();
      clear_ctl();
      c++;
      chk("hold_mem_req_valid", mem_req_valid_o, 1);
      chk("hold_mem_req_addr", mem_req_addr_o, line_a);
    end
    apply_ctl(c, kill_cyc, inval_cyc);
    mem_req_ready_i = 1'b1;
    step();
    mem_req_ready_i = 1'b0;
    clear_ctl();
    c++;
    chk("mem_req_dropped", mem_req_valid_o, 0);
    for (int i = 0; i < rsp_dly; i++) begin
      apply_ctl(c, kill_cyc, inval_cyc);
      step();
      clear_ctl();
      c++;
      chk("wait_no_resp", icache_resp_valid_o, 0);
    end
    apply_ctl(c, kill_cyc, inval_cyc);
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = fill;
    step();
    mem_resp_valid_i = 1'b0;
    clear_ctl();
    m_line[s]  = a[ADDR_W-1:4];
    m_data[s]  = fill;
    m_valid[s] = !g_invd;
    chk("refill_resp_valid", icache_resp_valid_o, !g_killed);
    if (!g_killed) begin
      chk("refill_resp_data", icache_resp_datablock_o, fill);
      chk("refill_resp_vaddr", icache_resp_vaddr_o, a);
    end
    chk("resp_state_ready_low", icache_req_ready_o, 0);
    step();
    chk("back_idle_ready", icache_req_ready_o, 1);
    chk("back_idle_no_resp", icache_resp_valid_o, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, icache_req_ready_o, 0);
    chk({tag, "_resp_valid"}, icache_resp_valid_o, 0);
    chk({tag, "_resp_data"}, icache_resp_datablock_o, 0);
    chk({tag, "_resp_vaddr"}, icache_resp_vaddr_o, 0);
    chk({tag, "_mem_req_valid"}, mem_req_valid_o, 0);
    chk({tag, "_mem_req_addr"}, mem_req_addr_o, 0);
    chk({tag, "_hit"}, hit_o, 0);
    chk({tag, "_miss"}, miss_o, 0);
  endtask

  localparam logic [LINE_W-1:0] DEADBEEF = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;

  initial begin
    bit                h;
    addr_t             a;
    logic [29:0]       tag_pool [3];
    int                set_pool [3];
    int                kind, rdy, rsp, kc, ic, span;
    logic [LINE_W-1:0] fill;

    model_clear();

    // Reset state
    #1;
    check_all_zero("reset");
    step();
    step();
    rstn_i = 1'b1;
    step();
    chk("ready_after_reset", icache_req_ready_o, 1);

    // Cold miss then hit
    access(40'h80001230, 0, 3, -1, -1, DEADBEEF, h);
    chk("cold_is_miss", h, 0);
    access(40'h8000123C, 0, 0, -1, -1, '0, h);
    chk("rereq_is_hit", h, 1);

    // Streaming hits on consecutive cycles
    for (int i = 0; i < 4; i++) begin
      a = 40'h80001230 + addr_t'(4 * i);
      chk("stream_ready", icache_req_ready_o, 1);
      drive_req(a);
      step();
      chk("stream_resp_valid", icache_resp_valid_o, 1);
      chk("stream_hit", hit_o, 1);
      chk("stream_data", icache_resp_datablock_o, DEADBEEF);
      chk("stream_vaddr", icache_resp_vaddr_o, a);
    end
    icache_req_valid_i = 1'b0;

    // Conflict miss in the same set
    access(40'h80001630, 1, 1, -1, -1, {4{32'h1630_1630}}, h);
    chk("conflict_miss", h, 0);
    access(40'h80001230, 0, 2, -1, -1, DEADBEEF, h);
    chk("evicted_misses", h, 0);

    // Kill during MISS_WAIT: no response, line still filled
    access(40'h80004450, 0, 2, 2, -1, {4{32'hABCD_4450}}, h);
    chk("kill_was_miss", h, 0);
    access(40'h80004454, 0, 0, -1, -1, '0, h);
    chk("after_kill_hit", h, 1);

    // Invalidate during MISS_REQ: response returned, line not kept
    access(40'h80005560, 2, 1, -1, 1, {4{32'h5560_0001}}, h);
    chk("inval_was_miss", h, 0);
    access(40'h80005560, 0, 1, -1, -1, {4{32'h5560_0002}}, h);
    chk("after_inval_miss", h, 0);

    // Memory request held off for 5 cycles
    access(40'h80006670, 5, 1, -1, -1, {4{32'h6670_6670}}, h);
    chk("hold_was_miss", h, 0);

    // Blocked acceptance in IDLE: kill and invalidate
    drive_req(40'h80006670);
    icache_req_kill_i = 1'b1;
    step();
    clear_ctl();
    icache_req_valid_i = 1'b0;
    chk("kill_blocks_resp", icache_resp_valid_o, 0);
    chk("kill_blocks_hit", hit_o, 0);
    drive_req(40'h80006670);
    icache_invalidate_i = 1'b1;
    model_clear();
    step();
    clear_ctl();
    icache_req_valid_i = 1'b0;
    chk("inval_blocks_resp", icache_resp_valid_o, 0);
    chk("inval_blocks_miss", miss_o, 0);
    access(40'h80006670, 0, 0, -1, -1, {4{32'h6670_0002}}, h);
    chk("inval_flushed_line", h, 0);

    // Reset while waiting for refill data
    drive_req(40'h80007780);
    step();
    icache_req_valid_i = 1'b0;
    chk("rst_case_miss", miss_o, 1);
    mem_req_ready_i = 1'b1;
    step();
    mem_req_ready_i = 1'b0;
    rstn_i = 1'b0;
    #1;
    check_all_zero("midrst");
    model_clear();
    step();
    step();
    rstn_i = 1'b1;
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = {4{32'h7780_7780}};
    step();
    mem_resp_valid_i = 1'b0;
    chk("late_resp_ignored", icache_resp_valid_o, 0);
    chk("late_resp_no_miss_state", icache_req_ready_o, 1);
    access(40'h80007780, 0, 1, -1, -1, {4{32'h7780_0001}}, h);
    chk("post_reset_miss", h, 0);

    // Randomized traffic over a small set/tag pool to mix hits and conflicts
    tag_pool[0] = 30'h0020_0004;
    tag_pool[1] = 30'h0020_0005;
    tag_pool[2] = 30'h3FFF_FFFF;
    set_pool[0] = 0;
    set_pool[1] = 7;
    set_pool[2] = 63;
    for (int it = 0; it < 60; it++) begin
      a = (addr_t'(tag_pool[$urandom_range(0, 2)]) << 10)
        | (addr_t'(set_pool[$urandom_range(0, 2)]) << 4)
        | addr_t'($urandom_range(0, 15));
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        drive_req(a);
        icache_req_kill_i = 1'b1;
        step();
        clear_ctl();
        icache_req_valid_i = 1'b0;
        chk("rnd_kill_block", icache_resp_valid_o | hit_o | miss_o, 0);
      end else if (kind == 1) begin
        drive_req(a);
        icache_invalidate_i = 1'b1;
        model_clear();
        step();
        clear_ctl();
        icache_req_valid_i = 1'b0;
        chk("rnd_inval_block", icache_resp_valid_o | hit_o | miss_o, 0);
      end else begin
        rdy  = int'($urandom_range(0, 3));
        rsp  = int'($urandom_range(0, 3));
        span = rdy + rsp + 1;
        kc   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, span)) : -1;
        ic   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, span)) : -1;
        fill = {$urandom, $urandom, $urandom, $urandom};
        access(a, rdy, rsp, kc, ic, fill, h);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule : tb_icache_line_responder
`default_nettype wire

// File: doc/icache_line_responder.md
Name: icache_line_responder

Overview:
Responder end of the fetch-side icache protocol. It accepts idx/vpn line requests from the fetch interface and returns a 128-bit line plus the request vaddr. It is a small direct-mapped, flop-based line store: hits are served from local storage, and misses are refilled from a single-beat memory port. It serves as the synthesizable icache stand-in for bring-up and unit-level co-simulation of the fetch path. Translation is identity (vaddr = paddr).

Parameters:
NUM_SETS, 64, number of direct-mapped lines; power of 2, 4..256.
ADDR_W, 40, request address width (= PHY_VIRT_MAX_ADDR_SIZE).
LINE_W, 128, line width in bits; fixed at 16 bytes.

Ports:
clk_i  in  1  clock.
rstn_i  in  1  asynchronous, active-low reset.
icache_req_valid_i  in  1  request valid.
icache_req_bits_idx_i  in  12  vaddr[11:0].
icache_req_bits_vpn_i  in  ADDR_W-12  vaddr[ADDR_W-1:12].
icache_req_kill_i  in  1  abort an outstanding miss and block acceptance this cycle.
icache_invalidate_i  in  1  flash-invalidate all lines.
icache_req_ready_o  out  1  request may be accepted this cycle.
icache_resp_valid_o  out  1  response valid, 1-cycle pulse.
icache_resp_datablock_o  out  LINE_W  returned line.
icache_resp_vaddr_o  out  ADDR_W  address of the request being answered.
mem_req_valid_o  out  1  refill request.
mem_req_addr_o  out  ADDR_W  line-aligned refill address, [3:0]=0.
mem_req_ready_i  in  1  memory accepts the refill request.
mem_resp_valid_i  in  1  refill data valid.
mem_resp_data_i  in  LINE_W  refill line.
hit_o  out  1  PMU pulse, one per accepted hit.
miss_o  out  1  PMU pulse, one per accepted miss.

Behaviour:
- Address decomposition: addr = {vpn, idx}; set = addr[4+log2(NUM_SETS)-1:4]; tag = addr[ADDR_W-1:4+log2(NUM_SETS)].
- Reset values: state IDLE; all line valid bits 0; every output 0. Tag/data storage is not reset.
- States:
  - IDLE: ready_o=1; serves hits.
  - MISS_REQ: mem_req_valid_o=1 until mem_req_ready_i.
  - MISS_WAIT: waits for mem_resp_valid_i.
  - RESP: one cycle; presents the refill response.
- Acceptance: a request is accepted when req_valid_i & ready_o & ~kill_i & ~invalidate_i. In the acceptance cycle (T) the set is read combinationally and compared against the tag.
- Hit at T:
  - resp_valid_o=1 at T+1, with registered datablock and vaddr.
  - hit_o=1 at T+1; state stays IDLE.
  - Back-to-back hits sustain one response per cycle.
- Miss at T:
  - miss_o=1 at T+1; state goes to MISS_REQ at T+1 with mem_req_addr_o = {addr[ADDR_W-1:4], 4'b0}.
  - ready_o=0 in every non-IDLE state.
- MISS_REQ -> MISS_WAIT on mem_req_ready_i; mem_req_valid_o and mem_req_addr_o hold stable until then.
- MISS_WAIT -> RESP on mem_resp_valid_i.
  - That cycle: data and tag are written, and the valid bit is set unless the refill is marked invalidated.
  - resp_valid_o at the RESP cycle carries mem_resp_data_i (registered) and the miss vaddr, unless the miss is marked killed.
  - RESP -> IDLE.
- kill_i:
  - In any non-IDLE state it marks the outstanding miss as killed; no response is emitted for it.
  - The refill still completes and fills the line; the memory handshake is never abandoned.
  - In IDLE it only blocks acceptance.
  - It does not suppress a hit response already registered for T+1.
- invalidate_i:
  - Clears all valid bits at the next edge.
  - If a refill is in flight, the miss is marked invalidated: data is written, valid stays 0, and the response is still returned.
  - A request with invalidate_i in the same cycle is not accepted.
- Simultaneous mem_resp_valid_i and kill_i in MISS_WAIT: the fill happens and no response is emitted.
- mem_resp_valid_i outside MISS_WAIT is ignored.
- Reset mid-refill: returns to IDLE immediately (async) and all valid bits clear. A late mem_resp is ignored per the rule above.

Decomposition:
- drac_pkg (reused): icache_line_t, icache_idx_t, icache_vpn_t, addr_t.
- drac_pkg (new): icache_resp_state_t enum {IDLE, MISS_REQ, MISS_WAIT, RESP}.
- One sub-module, icache_line_array: tag/data flop storage with a valid-bit vector. It provides a combinational read port, one write port, and flash clear.

Test Plan:
- Cold miss, then hit:
  - Stimulus: req at addr 0x80001230; mem_req_ready_i=1; mem_resp data 0xDEAD..BEEF after 3 cycles.
  - Required: mem_req_addr_o=0x80001230; miss_o pulse; one resp with that data and vaddr 0x80001230.
  - Stimulus: re-request 0x8000123C.
  - Required: resp next cycle, same line, hit_o=1, no mem_req.
- Streaming hits: 4 consecutive requests 0x80001230/34/38/3C after the fill -> 4 resps on 4 consecutive cycles; ready_o stays 1.
- Conflict miss:
  - Stimulus: fill 0x80001230, then request 0x80001630 (same set, NUM_SETS=64).
  - Required: miss and refill at 0x80001630; 0x80001230 then misses again.
- Kill during MISS_WAIT: kill_i pulse -> no resp_valid_o; the fill completes; a subsequent request to the same line hits in 1 cycle.
- Invalidate during refill: invalidate_i in MISS_REQ -> response still returned; a re-request of the same line misses.
- Reset and handshake hold:
  - Stimulus: rstn_i low in MISS_WAIT.
  - Required: all outputs 0 immediately; a post-reset mem_resp_valid_i is ignored; the first request misses.
  - Stimulus: mem_req_ready_i held 0 for 5 cycles.
  - Required: mem_req_valid_o and mem_req_addr_o stay stable.
